// File: rtl/sm_regdump_uart.sv
// sm_regdump_uart: walks a register-file debug port and prints each register as
//   8 uppercase hex digits + CR LF on an 8N1 UART line.
// Latency: first start bit two cycles after start is accepted; each register takes
//   2 + 100*CLK_DIV cycles, plus one NEXT cycle between registers.
// Backpressure: none; the UART line is free-running, and start is ignored while busy.
// Ports:
//   clk      - single clock, rising edge
//   rst_p    - asynchronous, active-low reset
//   start    - request one dump pass (sampled in IDLE only)
//   regAddr  - debug read address to the register file
//   regData  - combinational read data for regAddr (settles one cycle after a change)
//   tx       - UART serial output, idle high
//   busy     - pass in progress
//   done     - one-cycle pulse at the end of a pass
module sm_regdump_uart #(
  parameter int unsigned CLK_DIV   = 87,
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst_p,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    NEXT    = 3'd4
  } state_t;

  localparam logic [15:0] BAUD_LAST  = 16'(CLK_DIV - 1);
  localparam logic [4:0]  FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0]  LAST_ADDR  = 5'(LAST_REG);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] hold;      // register value being printed, frozen at CAPTURE
  logic [15:0] baud_cnt;  // cycles into the current bit, 0..CLK_DIV-1
  logic [3:0]  bit_idx;   // 0 = start bit, 1..8 = data LSB first, 9 = stop bit
  logic [3:0]  char_idx;  // 0..7 = hex digits MSB first, 8 = CR, 9 = LF
  logic        bit_end;
  logic        reg_end;
  logic        last_reg;
  logic [2:0]  digit;
  logic [3:0]  nibble;
  logic [7:0]  char_dat;

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign reg_end  = bit_end && (bit_idx == 4'd9) && (char_idx == 4'd9);
  assign last_reg = (regAddr >= LAST_ADDR);

  // Character index 0 prints the top nibble, so the digit position counts down.
  assign digit  = 3'd7 - char_idx[2:0];
  assign nibble = hold[{digit, 2'b00} +: 4];

  always_comb begin
    char_dat = 8'h0A;
    if (char_idx < 4'd8) begin
      if (nibble < 4'd10) char_dat = {4'h3, nibble};
      else                char_dat = 8'h37 + {4'h0, nibble};
    end else if (char_idx == 4'd8) begin
      char_dat = 8'h0D;
    end
  end

  // The line is driven straight from state so reset forces it high at once.
  always_comb begin
    tx = 1'b1;
    if (state == SEND) begin
      case (bit_idx)
        4'd0:    tx = 1'b0;
        4'd9:    tx = 1'b1;
        default: tx = char_dat[3'(bit_idx - 4'd1)];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_p) begin
    if (!rst_p) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ADDR;
      end
      ADDR:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = SEND;
      SEND:    if (reg_end) state_nxt = NEXT;
      NEXT: begin
        // The final NEXT cycle is the done cycle; busy already drops here.
        if (last_reg) begin
          state_nxt = IDLE;
          busy      = 1'b0;
          done      = 1'b1;
        end else begin
          state_nxt = ADDR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_p) begin
    if (!rst_p) begin
      regAddr  <= FIRST_ADDR;
      hold     <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
    end else begin
      case (state)
        IDLE: if (start) regAddr <= FIRST_ADDR;
        CAPTURE: begin
          hold     <= regData;
          char_idx <= '0;
          bit_idx  <= '0;
          baud_cnt <= '0;
        end
        SEND: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 4'd9) begin
              bit_idx <= '0;
              // Parks on LF at the end of a register; CAPTURE rearms it.
              if (char_idx != 4'd9) char_idx <= char_idx + 4'd1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        NEXT: if (!last_reg) regAddr <= regAddr + 5'd1;
        default: ;
      endcase
    end
  end

endmodule
